// File: rtl/kmer_hasher.sv
// Streams 2-bit bases into forward/reverse-complement k-mer windows and emits a hashed signature per complete k-mer.
// Latency 2 cycles from accepted base to valid_out; no backpressure, one k-mer per cycle.
module kmer_hasher #(
    parameter int          K               = 16,
    parameter int          SIGNATURE_WIDTH = 32,
    parameter int          INDEX_WIDTH     = 10,
    parameter int          CANONICAL       = 1,
    parameter logic [31:0] SEED            = 32'h9E3779B9,
    parameter logic [31:0] MULT            = 32'h85EBCA6B
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [1:0]                 base_in,
    input  logic                       start_in,
    output logic                       valid_out,
    output logic [SIGNATURE_WIDTH-1:0] signature_out,
    output logic [INDEX_WIDTH-1:0]     index_out
);

    localparam int KW = 2 * K;
    localparam int SW = SIGNATURE_WIDTH;
    localparam int FW = $clog2(K + 1);
    localparam logic [FW-1:0] K_FILL = FW'(K);

    logic [KW-1:0]          fwd, rc;
    logic [KW-1:0]          fwd_base, rc_base, fwd_nxt, rc_nxt, kmer_nxt;
    logic [FW-1:0]          fill, fill_base, fill_nxt;
    logic [INDEX_WIDTH-1:0] pos, pos_base;
    logic                   kmer_done;

    logic                   s0_vld;
    logic [KW-1:0]          s0_kmer;
    logic [INDEX_WIDTH-1:0] s0_idx;
    logic                   s1_vld;
    logic [SW-1:0]          h1;
    logic [INDEX_WIDTH-1:0] s1_idx;

    // A start base behaves as if the windows were empty before it is shifted in.
    always_comb begin
        fwd_base  = start_in ? '0 : fwd;
        rc_base   = start_in ? '0 : rc;
        fill_base = start_in ? '0 : fill;
        pos_base  = start_in ? '0 : pos;
        fwd_nxt   = {fwd_base[KW-3:0], base_in};
        rc_nxt    = {~base_in, rc_base[KW-1:2]};
        fill_nxt  = (fill_base == K_FILL) ? K_FILL : fill_base + FW'(1);
        kmer_done = valid_in && (fill_nxt == K_FILL);
        kmer_nxt  = fwd_nxt;
        if (CANONICAL != 0 && rc_nxt < fwd_nxt) begin
            kmer_nxt = rc_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd  <= '0;
            rc   <= '0;
            fill <= '0;
            pos  <= '0;
        end else if (valid_in) begin
            fwd  <= fwd_nxt;
            rc   <= rc_nxt;
            fill <= fill_nxt;
            pos  <= kmer_done ? pos_base + INDEX_WIDTH'(1) : pos_base;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld  <= 1'b0;
            s0_kmer <= '0;
            s0_idx  <= '0;
        end else begin
            s0_vld <= kmer_done;
            if (kmer_done) begin
                s0_kmer <= kmer_nxt;
                s0_idx  <= pos_base;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            h1     <= '0;
            s1_idx <= '0;
        end else begin
            s1_vld <= s0_vld;
            if (s0_vld) begin
                h1     <= (SW'(s0_kmer) ^ SW'(SEED)) * SW'(MULT);
                s1_idx <= s0_idx;
            end
        end
    end

    // Outputs hold their last value between k-mers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out     <= 1'b0;
            signature_out <= '0;
            index_out     <= '0;
        end else begin
            valid_out <= s1_vld;
            if (s1_vld) begin
                signature_out <= h1 ^ (h1 >> (SW / 2));
                index_out     <= s1_idx;
            end
        end
    end

endmodule

// File: tb/tb_kmer_hasher.sv
// Directed bench for kmer_hasher: four instances share one base stream (forward-only, canonical, 3-bit index, default hash).
module tb_kmer_hasher;

    logic        clk, rst, valid_in, start_in;
    logic [1:0]  base_in;
    logic        vo_f, vo_c, vo_w, vo_d;
    logic [31:0] sig_f, sig_c, sig_w, sig_d;
    logic [9:0]  idx_f, idx_c, idx_d;
    logic [2:0]  idx_w;
    int          checks, errors;

    kmer_hasher #(.K(4), .SIGNATURE_WIDTH(32), .INDEX_WIDTH(10), .CANONICAL(0), .SEED(32'h0), .MULT(32'h1)) u_fwd (
        .clk(clk), .rst(rst), .valid_in(valid_in), .base_in(base_in), .start_in(start_in),
        .valid_out(vo_f), .signature_out(sig_f), .index_out(idx_f));

    kmer_hasher #(.K(4), .SIGNATURE_WIDTH(32), .INDEX_WIDTH(10), .CANONICAL(1), .SEED(32'h0), .MULT(32'h1)) u_can (
        .clk(clk), .rst(rst), .valid_in(valid_in), .base_in(base_in), .start_in(start_in),
        .valid_out(vo_c), .signature_out(sig_c), .index_out(idx_c));

    kmer_hasher #(.K(4), .SIGNATURE_WIDTH(32), .INDEX_WIDTH(3), .CANONICAL(0), .SEED(32'h0), .MULT(32'h1)) u_w3 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .base_in(base_in), .start_in(start_in),
        .valid_out(vo_w), .signature_out(sig_w), .index_out(idx_w));

    kmer_hasher #(.K(4), .SIGNATURE_WIDTH(32), .INDEX_WIDTH(10), .CANONICAL(1)) u_def (
        .clk(clk), .rst(rst), .valid_in(valid_in), .base_in(base_in), .start_in(start_in),
        .valid_out(vo_d), .signature_out(sig_d), .index_out(idx_d));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_sig(input logic [31:0] kmer, input logic [31:0] seed, input logic [31:0] mult);
        logic [31:0] h;
        h = (kmer ^ seed) * mult;
        return h ^ (h >> 16);
    endfunction

    // Drive one cycle of input, then sample just after the rising edge.
    task automatic cyc(input logic v, input logic [1:0] b, input logic s);
        valid_in = v;
        base_in  = b;
        start_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (vo_f !== 1'b0) begin errors++; $display("FAIL reset_vo got=%0b exp=0", vo_f); end
        checks++; if (sig_f !== 32'h0) begin errors++; $display("FAIL reset_sig got=%h exp=0", sig_f); end
        checks++; if (idx_f !== 10'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx_f); end
        checks++; if (vo_d !== 1'b0 || sig_d !== 32'h0) begin errors++; $display("FAIL reset_def got=%0b/%h exp=0/0", vo_d, sig_d); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_forward;
        cyc(1'b1, 2'd0, 1'b1);
        cyc(1'b1, 2'd1, 1'b0);
        cyc(1'b1, 2'd2, 1'b0);
        cyc(1'b1, 2'd3, 1'b0);
        checks++; if (vo_f !== 1'b0) begin errors++; $display("FAIL fwd_lat0 got=%0b exp=0", vo_f); end
        cyc(1'b1, 2'd0, 1'b0);
        checks++; if (vo_f !== 1'b0) begin errors++; $display("FAIL fwd_lat1 got=%0b exp=0", vo_f); end
        cyc(1'b0, 2'd0, 1'b0);
        checks++; if (vo_f !== 1'b1 || sig_f !== 32'h1B || idx_f !== 10'd0)
            begin errors++; $display("FAIL fwd_k0 got=%0b/%h/%0d exp=1/0000001b/0", vo_f, sig_f, idx_f); end
        cyc(1'b0, 2'd0, 1'b0);
        checks++; if (vo_f !== 1'b1 || sig_f !== 32'h6C || idx_f !== 10'd1)
            begin errors++; $display("FAIL fwd_k1 got=%0b/%h/%0d exp=1/0000006c/1", vo_f, sig_f, idx_f); end
        cyc(1'b0, 2'd0, 1'b0);
        checks++; if (vo_f !== 1'b0 || sig_f !== 32'h6C || idx_f !== 10'd1)
            begin errors++; $display("FAIL fwd_hold got=%0b/%h/%0d exp=0/0000006c/1", vo_f, sig_f, idx_f); end
        idle(2);
    endtask

    task automatic test_canonical;
        cyc(1'b1, 2'd3, 1'b1);
        repeat (3) cyc(1'b1, 2'd3, 1'b0);
        idle(2);
        checks++; if (vo_c !== 1'b1 || sig_c !== 32'h0 || idx_c !== 10'd0)
            begin errors++; $display("FAIL can_tttt got=%0b/%h/%0d exp=1/00000000/0", vo_c, sig_c, idx_c); end
        checks++; if (sig_f !== 32'hFF) begin errors++; $display("FAIL fwd_tttt got=%h exp=000000ff", sig_f); end
        cyc(1'b1, 2'd2, 1'b0);
        idle(2);
        checks++; if (vo_c !== 1'b1 || sig_c !== 32'h40 || idx_c !== 10'd1)
            begin errors++; $display("FAIL can_tttg got=%0b/%h/%0d exp=1/00000040/1", vo_c, sig_c, idx_c); end
        checks++; if (sig_f !== 32'hFE) begin errors++; $display("FAIL fwd_tttg got=%h exp=000000fe", sig_f); end
        cyc(1'b1, 2'd0, 1'b1);
        repeat (3) cyc(1'b1, 2'd0, 1'b0);
        idle(2);
        checks++; if (vo_c !== 1'b1 || sig_c !== 32'h0 || idx_c !== 10'd0)
            begin errors++; $display("FAIL can_aaaa got=%0b/%h/%0d exp=1/00000000/0", vo_c, sig_c, idx_c); end
        checks++; if (sig_f !== 32'h0) begin errors++; $display("FAIL fwd_aaaa got=%h exp=00000000", sig_f); end
        idle(2);
    endtask

    task automatic test_gap;
        cyc(1'b1, 2'd0, 1'b1);
        cyc(1'b1, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'd3, 1'b0);
            checks++; if (vo_f !== 1'b0) begin errors++; $display("FAIL gap_vo%0d got=%0b exp=0", i, vo_f); end
        end
        cyc(1'b1, 2'd2, 1'b0);
        cyc(1'b1, 2'd3, 1'b0);
        cyc(1'b0, 2'd0, 1'b0);
        checks++; if (vo_f !== 1'b0) begin errors++; $display("FAIL gap_early got=%0b exp=0", vo_f); end
        cyc(1'b0, 2'd0, 1'b0);
        checks++; if (vo_f !== 1'b1 || sig_f !== 32'h1B || idx_f !== 10'd0)
            begin errors++; $display("FAIL gap_k got=%0b/%h/%0d exp=1/0000001b/0", vo_f, sig_f, idx_f); end
        cyc(1'b0, 2'd0, 1'b0);
        checks++; if (vo_f !== 1'b0) begin errors++; $display("FAIL gap_single got=%0b exp=0", vo_f); end
        idle(1);
    endtask

    task automatic test_restart;
        logic [1:0]  seq [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic        st  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int          pulses = 0;
        logic [31:0] last_sig = '0;
        logic [9:0]  last_idx = '0;
        for (int i = 0; i < 13; i++) begin
            if (i < 9) cyc(1'b1, seq[i], st[i]);
            else       cyc(1'b0, 2'd0, 1'b0);
            if (vo_f === 1'b1) begin
                pulses++;
                last_sig = sig_f;
                last_idx = idx_f;
            end
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL restart_count got=%0d exp=3", pulses); end
        checks++; if (last_sig !== 32'hB1 || last_idx !== 10'd2)
            begin errors++; $display("FAIL restart_inflight got=%h/%0d exp=000000b1/2", last_sig, last_idx); end
    endtask

    task automatic test_wrap;
        int cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (i < 12) cyc(1'b1, 2'(i % 4), (i == 0));
            else        cyc(1'b0, 2'd0, 1'b0);
            if (vo_w === 1'b1) begin
                checks++; if (idx_w !== 3'(cnt)) begin errors++; $display("FAIL wrap_idx%0d got=%0d exp=%0d", cnt, idx_w, cnt % 8); end
                cnt++;
            end
        end
        checks++; if (cnt != 9) begin errors++; $display("FAIL wrap_count got=%0d exp=9", cnt); end
    endtask

    task automatic test_reset_mid;
        logic [1:0] tail [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
        logic [31:0] exp_def;
        cyc(1'b1, 2'd0, 1'b1);
        cyc(1'b1, 2'd1, 1'b0);
        cyc(1'b1, 2'd2, 1'b0);
        cyc(1'b1, 2'd3, 1'b0);
        cyc(1'b1, 2'd0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0);
        checks++; if (vo_f !== 1'b1) begin errors++; $display("FAIL rmid_pre got=%0b exp=1", vo_f); end
        rst = 1'b1;
        #1;
        checks++; if (vo_f !== 1'b0 || sig_f !== 32'h0 || idx_f !== 10'd0)
            begin errors++; $display("FAIL rmid_async got=%0b/%h/%0d exp=0/00000000/0", vo_f, sig_f, idx_f); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, tail[i], 1'b0);
            checks++; if (vo_f !== 1'b0) begin errors++; $display("FAIL rmid_flush%0d got=%0b exp=0", i, vo_f); end
        end
        cyc(1'b0, 2'd0, 1'b0);
        checks++; if (vo_f !== 1'b0) begin errors++; $display("FAIL rmid_lat got=%0b exp=0", vo_f); end
        cyc(1'b0, 2'd0, 1'b0);
        checks++; if (vo_f !== 1'b1 || sig_f !== 32'hB4 || idx_f !== 10'd0)
            begin errors++; $display("FAIL rmid_k got=%0b/%h/%0d exp=1/000000b4/0", vo_f, sig_f, idx_f); end
        exp_def = ref_sig(32'hB4, 32'h9E3779B9, 32'h85EBCA6B);
        checks++; if (vo_d !== 1'b1 || sig_d !== exp_def || idx_d !== 10'd0)
            begin errors++; $display("FAIL rmid_default got=%0b/%h/%0d exp=1/%h/0", vo_d, sig_d, idx_d, exp_def); end
        idle(2);
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        valid_in = 1'b0;
        base_in  = 2'd0;
        start_in = 1'b0;
        checks   = 0;
        errors   = 0;
        test_reset;
        test_forward;
        test_canonical;
        test_gap;
        test_restart;
        test_wrap;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kmer_hasher.md
KMER_HASHER -- requirements
Module: kmer_hasher

Interface
REQ-001 SHALL have parameter K, default 16, meaning k-mer length in bases.
REQ-002 SHALL have parameter SIGNATURE_WIDTH, default 32, meaning hash output width; 2*K <= SIGNATURE_WIDTH.
REQ-003 SHALL have parameter INDEX_WIDTH, default 10, meaning k-mer start-position width.
REQ-004 SHALL have parameter CANONICAL, default 1, meaning hash min(forward, reverse-complement) when 1 and forward only when 0.
REQ-005 SHALL have parameter SEED, default 32'h9E3779B9, meaning XOR seed (low SIGNATURE_WIDTH bits used).
REQ-006 SHALL have parameter MULT, default 32'h85EBCA6B, meaning multiplier (low SIGNATURE_WIDTH bits used).
REQ-007 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-008 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port valid_in  input  1  base_in valid this cycle.
REQ-010 SHALL have port base_in  input  2  nucleotide code A=0, C=1, G=2, T=3.
REQ-011 SHALL have port start_in  input  1  qualified by valid_in; base_in is the first base of a new sequence.
REQ-012 SHALL have port valid_out  output  1  signature_out/index_out valid; drives sorter valid_in.
REQ-013 SHALL have port signature_out  output  SIGNATURE_WIDTH  k-mer hash; drives sorter signature_in.
REQ-014 SHALL have port index_out  output  INDEX_WIDTH  0-based k-mer start position in sequence; drives sorter index_in.

Function
REQ-015 SHALL keep a forward window fwd (2*K bits) and, on an accepted base b, update fwd = {fwd[2K-3:0], b}.
REQ-016 SHALL keep a reverse-complement window rc (2*K bits) and, on an accepted base b, update rc = {3-b, rc[2K-1:2]}.
REQ-017 SHALL keep a fill counter saturating at K, incremented per accepted base.
REQ-018 SHALL, on valid_in=1 with start_in=1, clear fwd, rc, fill and the position counter before applying that base (fill becomes 1).
REQ-019 SHALL ignore start_in when valid_in=0.
REQ-020 SHALL, when an accepted base makes fill equal to K (new or saturated), mark stage 0 valid with kmer = CANONICAL ? min(fwd,rc) : fwd and idx = position counter.
REQ-021 SHALL advance the position counter (modulo 2^INDEX_WIDTH, wrap silently) on each stage-0-valid k-mer; first k-mer of a sequence has index 0.
REQ-022 SHALL, on valid_in=0, hold windows, fill and counter; pipeline keeps advancing with a bubble.
REQ-023 SHALL compute in stage 1: h1 = ((zero-extended kmer) XOR SEED) * MULT, truncated to SIGNATURE_WIDTH.
REQ-024 SHALL compute in stage 2 (registered output): signature_out = h1 XOR (h1 >> SIGNATURE_WIDTH/2).
REQ-025 SHALL give latency: base accepted at edge n produces valid_out=1 for exactly one cycle after edge n+2; throughput one k-mer per cycle.
REQ-026 SHALL keep valid_out low and signature_out/index_out holding their last value when no k-mer completes.
REQ-027 SHALL let k-mers already in stages 1-2 complete unaffected when start_in arrives.
REQ-028 SHALL emit no k-mer for a sequence shorter than K bases.

Reset
REQ-029 SHALL, while rst=1, clear fwd, rc, fill, position counter, all stage valids, valid_out, signature_out and index_out to 0, independent of clk.
REQ-030 SHALL, on reset mid-sequence, discard in-flight k-mers and treat the next accepted base as a sequence start.

Verification (K=4, SIGNATURE_WIDTH=32, SEED=0, MULT=1 unless noted)
REQ-031 SHALL cover: CANONICAL=0, start+A,C,G,T,A on consecutive cycles -> valid_out pulses 2 cycles after T with sig 0x1B idx 0, next cycle sig 0x6C idx 1.
REQ-032 SHALL cover: CANONICAL=1, sequence T,T,T,T -> sig 0x00 idx 0; A,A,A,A -> sig 0x00.
REQ-033 SHALL cover: A,C,(valid_in low 3 cycles),G,T -> single k-mer sig 0x1B idx 0, no valid_out during gap.
REQ-034 SHALL cover: start mid-sequence after 6 bases, new sequence of 3 bases -> no k-mer from new sequence; old in-flight k-mer still emitted.
REQ-035 SHALL cover: INDEX_WIDTH=3, 12-base sequence -> indices 0..7,0 wrap.
REQ-036 SHALL cover: rst asserted between bases 5 and 6 -> valid_out 0 immediately, then next base behaves as start, first k-mer idx 0; default SEED/MULT result matches reference model.
